// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding and default sizes for the FIR sequencer
package fir_pkg;

  localparam int NTAPS_DEF     = 16;
  localparam int DW_DEF        = 16;
  localparam int DRAIN_MAX_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    WIND,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } fir_seq_state_t;

endpackage

// File: rtl/fir_phase_cnt.sv
// rtl/fir_phase_cnt.sv - loadable up-counter with clear and terminal-count compare
module fir_phase_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  // clear beats load beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - sequencer driving wind/load/run control of a 16-tap FIR
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS     = NTAPS_DEF,
  parameter int DW        = DW_DEF,
  parameter int LENW      = 16,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] run_len,
  input  logic            abort,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [DW-1:0]   cfg_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic            fir_wind,
  output logic            fir_load,
  output logic            fir_in_valid,
  output logic [DW-1:0]   fir_data,
  input  logic            fir_out_valid,
  input  logic [DW-1:0]   fir_out,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  output logic            busy,
  output logic            done,
  output logic            timeout
);

  localparam int CW = $clog2(NTAPS + 1);
  localparam int TW = $clog2(DRAIN_MAX + 1);

  fir_seq_state_t  state;
  logic [LENW-1:0] run_len_q;
  logic [LENW-1:0] ocnt;
  logic [CW-1:0]   cnt;
  logic            cnt_tc;
  logic [LENW-1:0] scnt;
  logic            scnt_tc;
  logic [TW-1:0]   dtmr;
  logic            dtmr_tc;
  logic            cfg_hs;
  logic            s_hs;

  assign cfg_ready = ((state == WIND) || (state == LOAD)) && (cnt < CW'(NTAPS));
  assign s_ready   = (state == RUN) && (scnt < run_len_q);
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign s_hs      = s_valid && s_ready;
  assign busy      = (state != IDLE);

  fir_phase_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort || (state == IDLE) || (cfg_hs && cnt_tc)),
    .load     (1'b0),
    .load_val ('0),
    .inc      (cfg_hs),
    .limit    (CW'(NTAPS - 1)),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  fir_phase_cnt #(.W(LENW)) u_scnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort || (state == IDLE)),
    .load     (1'b0),
    .load_val ('0),
    .inc      (s_hs),
    .limit    (run_len_q - LENW'(1)),
    .count    (scnt),
    .tc       (scnt_tc)
  );

  // idle timer only runs in DRAIN and restarts on every FIR result
  fir_phase_cnt #(.W(TW)) u_dtmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort || (state != DRAIN) || fir_out_valid),
    .load     (1'b0),
    .load_val ('0),
    .inc      (dtmr != TW'(DRAIN_MAX)),
    .limit    (TW'(DRAIN_MAX - 1)),
    .count    (dtmr),
    .tc       (dtmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      run_len_q    <= '0;
      ocnt         <= '0;
      fir_wind     <= 1'b0;
      fir_load     <= 1'b0;
      fir_in_valid <= 1'b0;
      fir_data     <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      m_valid      <= fir_out_valid;
      m_data       <= fir_out;
      fir_wind     <= 1'b0;
      fir_load     <= 1'b0;
      fir_in_valid <= 1'b0;
      done         <= (state == DONE) && !abort;

      if (fir_out_valid && ((state == RUN) || (state == DRAIN)) && (ocnt != {LENW{1'b1}})) begin
        ocnt <= ocnt + LENW'(1);
      end

      if (abort) begin
        state <= IDLE;
        ocnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= WIND;
              run_len_q <= run_len;
              ocnt      <= '0;
              timeout   <= 1'b0;
            end
          end
          WIND: begin
            if (cfg_hs) begin
              fir_wind <= 1'b1;
              fir_data <= cfg_data;
              if (cnt_tc) state <= LOAD;
            end
          end
          LOAD: begin
            if (cfg_hs) begin
              fir_load <= 1'b1;
              fir_data <= cfg_data;
              if (cnt_tc) state <= (run_len_q == '0) ? DONE : RUN;
            end
          end
          RUN: begin
            if (s_hs) begin
              fir_in_valid <= 1'b1;
              fir_data     <= s_data;
              if (scnt_tc) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (ocnt == run_len_q) begin
              state <= DONE;
            end else if (!fir_out_valid && dtmr_tc) begin
              timeout <= 1'b1;
              state   <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] run_len;
  logic        abort;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        fir_wind;
  logic        fir_load;
  logic        fir_in_valid;
  logic [15:0] fir_data;
  logic        fir_out_valid;
  logic [15:0] fir_out;
  logic        m_valid;
  logic [15:0] m_data;
  logic        busy;
  logic        done;
  logic        timeout;

  always #5 clk = ~clk;

  fir_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .run_len       (run_len),
    .abort         (abort),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_data      (cfg_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .fir_wind      (fir_wind),
    .fir_load      (fir_load),
    .fir_in_valid  (fir_in_valid),
    .fir_data      (fir_data),
    .fir_out_valid (fir_out_valid),
    .fir_out       (fir_out),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_wind, n_load, n_in, n_done, n_mv, n_sready;
  int n_multi, n_lat_bad, n_hold_bad, n_fwd_bad, n_wdata_bad, n_ldata_bad;
  int exp_load, last_load_cyc, last_in_cyc, done_cyc, to_cyc, mv_at_done;
  int emit_limit, emitted;
  logic [15:0] prev_data;
  logic        pend_v;
  logic [15:0] pend_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_wind = 0; n_load = 0; n_in = 0; n_done = 0; n_mv = 0; n_sready = 0;
    n_multi = 0; n_lat_bad = 0; n_hold_bad = 0; n_fwd_bad = 0;
    n_wdata_bad = 0; n_ldata_bad = 0;
    exp_load = 1; last_load_cyc = -1; last_in_cyc = -1;
    done_cyc = -1; to_cyc = -1; mv_at_done = -1; emitted = 0;
  endtask

  // one clock: observe outputs 1 time unit after the edge, then let the FIR model respond
  task automatic step();
    logic exp_strobe;
    exp_strobe = ((cfg_valid && cfg_ready) || (s_valid && s_ready)) && !abort && !rst;
    pend_v = fir_out_valid;
    pend_d = fir_out;
    @(posedge clk);
    #1;
    cyc++;
    if (fir_wind) begin
      n_wind++;
      if (fir_data !== 16'hFFFF) n_wdata_bad++;
    end
    if (fir_load) begin
      n_load++;
      if (fir_data !== 16'(exp_load)) n_ldata_bad++;
      exp_load++;
      last_load_cyc = cyc;
    end
    if (fir_in_valid) begin
      n_in++;
      last_in_cyc = cyc;
    end
    if (int'(fir_wind) + int'(fir_load) + int'(fir_in_valid) > 1) n_multi++;
    if ((fir_wind | fir_load | fir_in_valid) !== exp_strobe) n_lat_bad++;
    if (!(fir_wind | fir_load | fir_in_valid) && (fir_data !== prev_data)) n_hold_bad++;
    prev_data = fir_data;
    if ((m_valid !== pend_v) || (pend_v && (m_data !== pend_d))) n_fwd_bad++;
    if (m_valid) n_mv++;
    if (s_ready) n_sready++;
    if (timeout && (to_cyc < 0)) to_cyc = cyc;
    if (done) begin
      n_done++;
      done_cyc = cyc;
      mv_at_done = n_mv;
    end
    fir_out_valid = fir_in_valid && (emitted < emit_limit);
    fir_out = fir_data ^ 16'hA5A5;
    if (fir_out_valid) emitted++;
  endtask

  task automatic do_start(input logic [15:0] rl);
    start = 1'b1;
    run_len = rl;
    step();
    start = 1'b0;
    run_len = 16'hBEEF;
  endtask

  // words 0..15 are coefficients 0xFFFF, 16..31 are preload samples 1..16; live samples are 1
  task automatic feed(input bit gap, input int abort_w, input int stop_s, input int budget);
    int widx;
    int sidx;
    bit fin;
    logic chs;
    logic shs;
    widx = 0;
    sidx = 0;
    fin = 1'b0;
    for (int i = 0; (i < budget) && !fin; i++) begin
      cfg_valid = (widx < 32) && (!gap || (i % 2 == 0));
      cfg_data = (widx < 16) ? 16'hFFFF : 16'(widx - 15);
      s_valid = 1'b1;
      s_data = 16'd1;
      abort = (abort_w >= 0) && (widx == abort_w);
      if (abort) cfg_valid = 1'b0;
      chs = cfg_valid && cfg_ready;
      shs = s_valid && s_ready;
      step();
      if (chs) widx++;
      if (shs) sidx++;
      if (abort) fin = 1'b1;
      if (n_done > 0) fin = 1'b1;
      if ((stop_s >= 0) && (sidx >= stop_s)) fin = 1'b1;
    end
    cfg_valid = 1'b0;
    s_valid = 1'b0;
    abort = 1'b0;
    if (!fin) chk("feed_budget", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; run_len = '0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0; s_valid = 1'b0; s_data = '0;
    fir_out_valid = 1'b0; fir_out = '0; emit_limit = 1000; prev_data = '0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", 32'(busy), 0);
    chk("rst_ctrl", 32'({fir_wind, fir_load, fir_in_valid, done, timeout, m_valid, cfg_ready, s_ready}), 0);
    chk("rst_data", 32'(fir_data), 0);

    // 1: back-to-back sequence, run_len 6
    clr_mon();
    do_start(16'd6);
    chk("t1_busy_start", 32'(busy), 1);
    feed(1'b0, -1, -1, 400);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_wind", n_wind, 16);
    chk("t1_wind_data", n_wdata_bad, 0);
    chk("t1_load", n_load, 16);
    chk("t1_load_data", n_ldata_bad, 0);
    chk("t1_in", n_in, 6);
    chk("t1_mv_at_done", mv_at_done, 6);
    repeat (3) step();
    chk("t1_done_once", n_done, 1);
    chk("t1_onehot", n_multi, 0);
    chk("t1_latency", n_lat_bad, 0);
    chk("t1_forward", n_fwd_bad, 0);

    // 2: cfg_valid every other cycle
    clr_mon();
    do_start(16'd6);
    feed(1'b1, -1, -1, 400);
    chk("t2_wind", n_wind, 16);
    chk("t2_load", n_load, 16);
    chk("t2_load_data", n_ldata_bad, 0);
    chk("t2_latency", n_lat_bad, 0);
    chk("t2_hold", n_hold_bad, 0);
    chk("t2_in", n_in, 6);
    chk("t2_done", n_done, 1);

    // 3: run_len 0 skips RUN
    clr_mon();
    do_start(16'd0);
    feed(1'b0, -1, -1, 200);
    chk("t3_load", n_load, 16);
    chk("t3_sready", n_sready, 0);
    chk("t3_in", n_in, 0);
    chk("t3_done", n_done, 1);
    chk("t3_done_lat", done_cyc - last_load_cyc, 1);

    // 4: FIR returns only 2 of 4 results
    clr_mon();
    emit_limit = 2;
    do_start(16'd4);
    feed(1'b0, -1, -1, 300);
    chk("t4_timeout", 32'(timeout), 1);
    chk("t4_to_lat", to_cyc - last_in_cyc, 64);
    chk("t4_done_lat", done_cyc - to_cyc, 1);
    chk("t4_done", n_done, 1);
    chk("t4_mv", n_mv, 2);
    emit_limit = 1000;
    step();
    chk("t4_sticky", 32'(timeout), 1);
    do_start(16'd5);
    chk("t4_cleared", 32'(timeout), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_idle", 32'(busy), 0);

    // 5: abort after the 9th preload word
    clr_mon();
    do_start(16'd3);
    feed(1'b0, 25, -1, 200);
    chk("t5_strobes", 32'({fir_wind, fir_load, fir_in_valid}), 0);
    chk("t5_readies", 32'({cfg_ready, s_ready}), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_load_cnt", n_load, 9);
    repeat (4) step();
    chk("t5_no_done", n_done, 0);
    clr_mon();
    do_start(16'd3);
    feed(1'b0, -1, -1, 300);
    chk("t5_re_wind", n_wind, 16);
    chk("t5_re_load", n_load, 16);
    chk("t5_re_data", n_ldata_bad, 0);
    chk("t5_re_done", n_done, 1);

    // 6: async reset mid-RUN, then a stray start during WIND
    clr_mon();
    do_start(16'd5);
    feed(1'b0, -1, 2, 200);
    chk("t6_in_before", 32'(fir_in_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", 32'({fir_wind, fir_load, fir_in_valid, busy, done, cfg_ready, s_ready, m_valid}), 0);
    chk("t6_rst_data", 32'(fir_data), 0);
    fir_out_valid = 1'b0;
    prev_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_mon();
    do_start(16'd3);
    start = 1'b1;
    run_len = 16'd9;
    step();
    start = 1'b0;
    feed(1'b0, -1, -1, 300);
    chk("t6_in", n_in, 3);
    chk("t6_done", n_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
